// File: rtl/sprite_renderer.sv
// sprite_renderer: parametrised sprite blitter for the VGA pipeline.
// Compares the raster position against a frame-latched sprite origin, drives
// the address of a synchronous sprite ROM and returns a registered colour plus
// sprite_on flag. Latency DrawX/DrawY -> outputs is ROM_LAT+2 cycles.
// Optional feature macro: SPRITE_COLORKEY_EN (texels equal to KEY_COLOR are
// treated as transparent; compared in the final stage).
module sprite_renderer #(
  parameter int                      SPRITE_W   = 32,
  parameter int                      SPRITE_H   = 16,
  parameter int                      SCALE_LOG2 = 0,
  parameter int                      COLOR_W    = 8,
  parameter int                      ROM_LAT    = 1,
  parameter logic [3*COLOR_W-1:0]    KEY_COLOR  = '0,
  parameter int                      ADDR_W     = $clog2(SPRITE_W*SPRITE_H)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_start,
  input  logic                 enable,
  input  logic [9:0]           pos_x,
  input  logic [9:0]           pos_y,
  input  logic                 mirror_x,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [3*COLOR_W-1:0] rom_data,
  output logic                 sprite_on,
  output logic [COLOR_W-1:0]   spr_R,
  output logic [COLOR_W-1:0]   spr_G,
  output logic [COLOR_W-1:0]   spr_B
);

  localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [10:0] SPAN_X = 11'(SPRITE_W << SCALE_LOG2);
  localparam logic [10:0] SPAN_Y = 11'(SPRITE_H << SCALE_LOG2);

`ifdef SPRITE_COLORKEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ARM, LIVE} state_t;

  // Frame-latched sprite origin; only changes on frame_start so a frame
  // never tears.
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       mir;
  } org_t;

  state_t st, st_nxt;
  org_t   org;
  logic   latch_en, live;

  // FSM state register
  always_ff @(posedge Clk) begin
    if (!Reset) st <= IDLE;
    else        st <= st_nxt;
  end

  // FSM next state; dropping enable returns to IDLE from anywhere
  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:    if (enable)      st_nxt = ARM;
      ARM:     if (frame_start) st_nxt = LIVE;
      LIVE:    st_nxt = LIVE;
      default: st_nxt = IDLE;
    endcase
    if (!enable) st_nxt = IDLE;
  end

  // FSM outputs: origin latch strobe and render qualifier
  always_comb begin
    latch_en = enable && frame_start && (st == ARM || st == LIVE);
    live     = (st == LIVE);
  end

  // Origin latch; a same-cycle hit still sees the old origin
  always_ff @(posedge Clk) begin
    if (!Reset)        org <= '0;
    else if (latch_en) org <= '{x: pos_x, y: pos_y, mir: mirror_x};
  end

  // Stage 0 combinational hit test and texel address, 11-bit so no wrap
  logic [10:0]       dx, dy, x_end, y_end;
  logic              in_x, in_y, hit;
  logic [COL_W-1:0]  col, col_m;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr_nxt;

  always_comb begin
    x_end    = {1'b0, org.x} + SPAN_X;
    y_end    = {1'b0, org.y} + SPAN_Y;
    in_x     = ({1'b0, DrawX} >= {1'b0, org.x}) && ({1'b0, DrawX} < x_end);
    in_y     = ({1'b0, DrawY} >= {1'b0, org.y}) && ({1'b0, DrawY} < y_end);
    hit      = live && enable && in_x && in_y;
    dx       = {1'b0, DrawX} - {1'b0, org.x};
    dy       = {1'b0, DrawY} - {1'b0, org.y};
    col      = COL_W'(dx >> SCALE_LOG2);
    row      = ROW_W'(dy >> SCALE_LOG2);
    col_m    = org.mir ? (COL_W'(SPRITE_W - 1) - col) : col;
    addr_nxt = ADDR_W'(row) * ADDR_W'(SPRITE_W) + ADDR_W'(col_m);
  end

  // Stage 0 address register; holds the last address when off-sprite
  always_ff @(posedge Clk) begin
    if (!Reset)   rom_addr <= '0;
    else if (hit) rom_addr <= addr_nxt;
  end

  // Hit flag shift register; vld_pipe[ROM_LAT] lines up with rom_data
  logic [ROM_LAT:0] vld_pipe;

  always_ff @(posedge Clk) begin
    if (!Reset) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[ROM_LAT-1:0], hit};
  end

  // Final stage: colour-key test and registered outputs
  logic opaque, on_nxt;

  always_comb begin
    opaque = !(KEY_EN && (rom_data == KEY_COLOR));
    on_nxt = vld_pipe[ROM_LAT] && opaque;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sprite_on <= 1'b0;
      spr_R     <= '0;
      spr_G     <= '0;
      spr_B     <= '0;
    end else begin
      sprite_on <= on_nxt;
      spr_R     <= on_nxt ? rom_data[3*COLOR_W-1:2*COLOR_W] : '0;
      spr_G     <= on_nxt ? rom_data[2*COLOR_W-1:COLOR_W]   : '0;
      spr_B     <= on_nxt ? rom_data[COLOR_W-1:0]           : '0;
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer: one 32x16 scale-1x instance and one
// scale-2x instance share the raster/control stimulus, each with its own
// 1-cycle ROM model.
module tb_sprite_renderer;

  logic       Clk = 1'b0;
  logic       Reset, frame_start, enable, mirror_x;
  logic [9:0] pos_x, pos_y, DrawX, DrawY;

  logic [8:0]  addr0, addr1;
  logic [23:0] rd0, rd1;
  logic        on0, on1;
  logic [7:0]  r0, g0, b0, r1, g1, b1;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  sprite_renderer #(.SPRITE_W(32), .SPRITE_H(16), .SCALE_LOG2(0), .COLOR_W(8),
                    .ROM_LAT(1), .KEY_COLOR(24'h0)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .enable(enable),
    .pos_x(pos_x), .pos_y(pos_y), .mirror_x(mirror_x),
    .DrawX(DrawX), .DrawY(DrawY), .rom_addr(addr0), .rom_data(rd0),
    .sprite_on(on0), .spr_R(r0), .spr_G(g0), .spr_B(b0));

  sprite_renderer #(.SPRITE_W(32), .SPRITE_H(16), .SCALE_LOG2(1), .COLOR_W(8),
                    .ROM_LAT(1), .KEY_COLOR(24'h0)) dut_s (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .enable(enable),
    .pos_x(pos_x), .pos_y(pos_y), .mirror_x(mirror_x),
    .DrawX(DrawX), .DrawY(DrawY), .rom_addr(addr1), .rom_data(rd1),
    .sprite_on(on1), .spr_R(r1), .spr_G(g1), .spr_B(b1));

  // ROM image: texel 5 is black, others {a[7:0], ~a[7:0], 8'h11}
  function automatic logic [23:0] romf(input logic [8:0] a);
    return (a == 9'd5) ? 24'h0 : {a[7:0], ~a[7:0], 8'h11};
  endfunction

  always_ff @(posedge Clk) begin
    rd0 <= romf(addr0);
    rd1 <= romf(addr1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold one pixel, check address after stage 0 and outputs after ROM_LAT+2
  task automatic probe(input string tag, input bit s, input int x, input int y,
                       input bit eon, input int eaddr, input logic [23:0] ergb);
    @(negedge Clk); DrawX = 10'(x); DrawY = 10'(y);
    @(negedge Clk); chk({tag, " addr"}, s ? 32'(addr1) : 32'(addr0), 32'(eaddr));
    repeat (2) @(negedge Clk);
    chk({tag, " on"},  s ? 32'(on1) : 32'(on0), 32'(eon));
    chk({tag, " rgb"}, s ? {8'h0, r1, g1, b1} : {8'h0, r0, g0, b0}, {8'h0, ergb});
  endtask

  task automatic pulse_fs();
    @(negedge Clk); frame_start = 1'b1;
    @(negedge Clk); frame_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b0; enable = 1'b1; frame_start = 1'b0; mirror_x = 1'b0;
    pos_x = 10'd100; pos_y = 10'd50; DrawX = 10'd100; DrawY = 10'd50;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst on",   32'(on0), 0);
    chk("rst addr", 32'(addr0), 0);
    chk("rst rgb",  {8'h0, r0, g0, b0}, 0);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    // ARM without frame_start: nothing rendered
    probe("arm", 0, 100, 50, 0, 0, 24'h0);
    pulse_fs();

    probe("org",   0, 100, 50, 1, 0,   24'h00FF11);
    probe("right", 0, 131, 50, 1, 31,  24'h1FE011);
    probe("xout",  0, 132, 50, 0, 31,  24'h0);
    probe("left",  0,  99, 50, 0, 31,  24'h0);
    probe("bot",   0, 100, 65, 1, 480, 24'hE01F11);
    probe("yout",  0, 100, 66, 0, 480, 24'h0);
    probe("top",   0, 100, 49, 0, 480, 24'h0);

    mirror_x = 1'b1;
    pulse_fs();
    probe("mir", 0, 100, 51, 1, 63, 24'h3FC011);

    // Mid-frame position change is not applied yet
    pos_x = 10'd200;
    probe("hold old", 0, 100, 50, 1, 31, 24'h1FE011);
    probe("hold new", 0, 200, 50, 0, 31, 24'h0);

    // frame_start with a hit: that pixel uses the old origin
    @(negedge Clk); frame_start = 1'b1; DrawX = 10'd100; DrawY = 10'd50;
    @(negedge Clk); frame_start = 1'b0; DrawX = 10'd101;
    chk("fs addr", 32'(addr0), 31);
    @(negedge Clk);
    chk("fs addr hold", 32'(addr0), 31);
    @(negedge Clk);
    chk("fs old on", 32'(on0), 1);
    @(negedge Clk);
    chk("fs new off", 32'(on0), 0);
    probe("moved",  0, 200, 50, 1, 31, 24'h1FE011);
    probe("moved1", 0, 201, 50, 1, 30, 24'h1EE111);
    probe("gone",   0, 100, 50, 0, 30, 24'h0);

    // enable drop mid-sprite
    @(negedge Clk); DrawX = 10'd200;
    @(negedge Clk); DrawX = 10'd201; enable = 1'b0;
    chk("en addr", 32'(addr0), 31);
    repeat (2) @(negedge Clk);
    chk("en last on", 32'(on0), 1);
    @(negedge Clk);
    chk("en off", 32'(on0), 0);
    probe("idle", 0, 201, 50, 0, 31, 24'h0);

    // Re-arm and hit the black texel
    enable = 1'b1; mirror_x = 1'b0; pos_x = 10'd100; pos_y = 10'd50;
    repeat (2) @(negedge Clk);
    pulse_fs();
`ifdef SPRITE_COLORKEY_EN
    probe("key", 0, 105, 50, 0, 5, 24'h0);
`else
    probe("key", 0, 105, 50, 1, 5, 24'h0);
`endif

    // Scale 2x instance at the origin
    pos_x = 10'd0; pos_y = 10'd0;
    pulse_fs();
    begin
      int exp_a [4] = '{0, 0, 1, 1};
      for (int i = 0; i <= 4; i++) begin
        @(negedge Clk);
        if (i > 0) chk($sformatf("s2 x%0d addr", i - 1), 32'(addr1), 32'(exp_a[i-1]));
        if (i < 4) begin DrawX = 10'(i); DrawY = 10'd0; end
      end
    end
    probe("s2 y31", 1,  0, 31, 1, 480, 24'hE01F11);
    probe("s2 y32", 1,  0, 32, 0, 480, 24'h0);
    probe("s2 x63", 1, 63,  0, 1, 31,  24'h1FE011);
    probe("s2 x64", 1, 64,  0, 0, 31,  24'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
